// File: rtl/if_pkg.sv
// Shared types and default sizes for the instruction-fetch queue.
package if_pkg;

    localparam int IF_ADDR_W = 32;
    localparam int IF_QDEPTH = 4;
    localparam int QPTR_W    = $clog2(IF_QDEPTH);

    typedef struct packed {
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_ADDR_W-1:0] pc_plus4;
        logic [31:0]          instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        NONE,
        JUMP,
        BRANCH,
        JR
    } redir_sel_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Circular buffer of fetched entries; when empty the head shows the last popped entry.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = IF_QDEPTH,
    parameter int WIDTH = 2 * IF_ADDR_W + 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic             valid,
    output logic             full,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [WIDTH-1:0] last_q;

    // NOTE: storage has no reset; count gates every read, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign valid = (count != '0);
    assign full  = (count == (PTR_W + 1)'(DEPTH));
    assign head  = valid ? mem[rd_ptr] : last_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: PC register, redirect mux and push/pop control around if_fetch_fifo.
// Optional macro IF_MISALIGN_CHK_EN: misaligned redirect targets raise a sticky fault_o.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                IMEM_AW  = 7,
    parameter int                QDEPTH   = IF_QDEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_f,
    input  logic               pcsrc_d,
    input  logic [ADDR_W-1:0]  pc_branch_d,
    input  logic               jump_d,
    input  logic [ADDR_W-1:0]  pc_jump_d,
    input  logic               jr_d,
    input  logic [ADDR_W-1:0]  pc_jr_d,
    output logic [IMEM_AW-1:0] imem_addr_o,
    input  logic [31:0]        imem_rdata_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [31:0]        instr_f,
    output logic [ADDR_W-1:0]  pc_f,
    output logic [ADDR_W-1:0]  pc_plus4_f,
    output logic               fault_o
);

    localparam int ENTRY_W = 2 * ADDR_W + 32;

    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  load_pc;
    logic [ENTRY_W-1:0] head;
    redir_sel_t         redir_sel;
    logic               redirect;
    logic               push;
    logic               pop;
    logic               full;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        redir_sel = NONE;
        if (jump_d) begin
            redir_sel = JUMP;
        end else if (pcsrc_d) begin
            redir_sel = BRANCH;
        end else if (jr_d) begin
            redir_sel = JR;
        end
    end

    always_comb begin
        target = pc_jr_d;
        case (redir_sel)
            JUMP:    target = pc_jump_d;
            BRANCH:  target = pc_branch_d;
            default: target = pc_jr_d;
        endcase
    end

    assign redirect = (redir_sel != NONE);
    assign pc_plus4 = pc_q + ADDR_W'(4);
    assign pop      = instr_valid_o & instr_ready_i & ~redirect;
    assign push     = ~redirect & ~stall_f & ~fault_o & (~full | pop);

`ifdef IF_MISALIGN_CHK_EN
    logic fault_q;

    assign load_pc = target;
    assign fault_o = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (redirect && (target[1:0] != 2'b00)) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign load_pc = target & ~ADDR_W'(3);
    assign fault_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= load_pc;
        end else if (push) begin
            pc_q <= pc_plus4;
        end
    end

    assign imem_addr_o = pc_q[IMEM_AW+1:2];

    if_fetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({pc_q, pc_plus4, imem_rdata_i}),
        .valid (instr_valid_o),
        .full  (full),
        .head  (head)
    );

    assign {pc_f, pc_plus4_f, instr_f} = head;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: vector table plus a scoreboard of fetched entries.
module tb_if_fetch_queue;
    import if_pkg::*;

`ifdef IF_MISALIGN_CHK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    typedef struct {
        logic        stall;
        logic        ready;
        logic        jump;
        logic        pcsrc;
        logic        jr;
        logic [31:0] tgt_j;
        logic [31:0] tgt_b;
        logic [31:0] tgt_r;
        logic        push;
        logic [31:0] exp_pc;
        logic        exp_valid;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        stall_f;
    logic        pcsrc_d;
    logic [31:0] pc_branch_d;
    logic        jump_d;
    logic [31:0] pc_jump_d;
    logic        jr_d;
    logic [31:0] pc_jr_d;
    logic [6:0]  imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic        fault_o;

    int unsigned  n_vec;
    int unsigned  n_fail;
    fetch_entry_t sb[$];
    fetch_entry_t last;
    logic [31:0]  cur_pc;
    logic         prev_valid;
    logic         exp_fault;
    vec_t         tbl[$];

    if_fetch_queue dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_f       (stall_f),
        .pcsrc_d       (pcsrc_d),
        .pc_branch_d   (pc_branch_d),
        .jump_d        (jump_d),
        .pc_jump_d     (pc_jump_d),
        .jr_d          (jr_d),
        .pc_jr_d       (pc_jr_d),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_f       (instr_f),
        .pc_f          (pc_f),
        .pc_plus4_f    (pc_plus4_f),
        .fault_o       (fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata_i = 32'h1111_0000 | {25'd0, imem_addr_o};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic stall, input logic ready, input logic jump,
                                input logic pcsrc, input logic jr, input logic [31:0] tj,
                                input logic [31:0] tgb, input logic [31:0] tr, input logic push,
                                input logic [31:0] pc, input logic valid);
        vec_t v;
        v.stall = stall; v.ready = ready; v.jump = jump; v.pcsrc = pcsrc; v.jr = jr;
        v.tgt_j = tj; v.tgt_b = tgb; v.tgt_r = tr;
        v.push = push; v.exp_pc = pc; v.exp_valid = valid;
        return v;
    endfunction

    // Drives one cycle: head is compared on a pop before the edge, state after it.
    task automatic apply_vec(input vec_t v);
        logic         redir;
        fetch_entry_t e;
        redir = v.jump | v.pcsrc | v.jr;
        stall_f       = v.stall;
        instr_ready_i = v.ready;
        jump_d        = v.jump;
        pcsrc_d       = v.pcsrc;
        jr_d          = v.jr;
        pc_jump_d     = v.tgt_j;
        pc_branch_d   = v.tgt_b;
        pc_jr_d       = v.tgt_r;
        #2;
        if (v.ready && prev_valid && !redir && sb.size() > 0) begin
            e = sb.pop_front();
            check("pop_instr", instr_f, e.instr);
            check("pop_pc", pc_f, e.pc);
            check("pop_pc_plus4", pc_plus4_f, e.pc_plus4);
            last = e;
        end
        if (redir) begin
            sb.delete();
            last = '0;
        end
        if (v.push) begin
            e.pc       = cur_pc;
            e.pc_plus4 = cur_pc + 32'd4;
            e.instr    = 32'h1111_0000 | ((cur_pc >> 2) & 32'h7f);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        check("imem_addr", {25'd0, imem_addr_o}, (v.exp_pc >> 2) & 32'h7f);
        check("valid", {31'd0, instr_valid_o}, {31'd0, v.exp_valid});
        check("fault", {31'd0, fault_o}, {31'd0, exp_fault});
        if (v.exp_valid && sb.size() > 0) begin
            check("head_pc", pc_f, sb[0].pc);
        end else if (!v.exp_valid) begin
            check("idle_pc", pc_f, last.pc);
            check("idle_instr", instr_f, last.instr);
        end
        cur_pc     = v.exp_pc;
        prev_valid = v.exp_valid;
    endtask

    initial begin
        n_vec = 0; n_fail = 0;
        last = '0; cur_pc = 32'h0; prev_valid = 1'b0; exp_fault = 1'b0;
        rst_n = 1'b0; stall_f = 1'b0; instr_ready_i = 1'b0;
        jump_d = 1'b0; pcsrc_d = 1'b0; jr_d = 1'b0;
        pc_jump_d = '0; pc_branch_d = '0; pc_jr_d = '0;

        // Fill to full, pop while full, dual redirect, stalled drain, jr under stall,
        // branch-over-jr priority, PC wrap at the top of the address space.
        //          st rd j  b  r  tj            tb            tr            psh pc            v
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'h4,        1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'h8,        1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'hC,        1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'h10,       1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   0, 32'h10,       1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'h14,       1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 32'h40,       32'h80,  32'h0,   0, 32'h40,       0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'h44,       1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'h48,       1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'h4C,       1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,        32'h0,   32'h0,   0, 32'h4C,       1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,        32'h0,   32'h0,   0, 32'h4C,       1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 32'h0,        32'h0,   32'h0,   0, 32'h4C,       0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 32'h0,        32'h0,   32'h100, 0, 32'h100,      0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'h104,      1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'h108,      1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 32'h0,        32'h200, 32'h300, 0, 32'h200,      0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h84,  0, 32'h84,       0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 32'hFFFFFFFC, 32'h0,   32'h0,   0, 32'hFFFFFFFC, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'h0,        1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,        32'h0,   32'h0,   1, 32'h4,        1));

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_f, 32'd0);
        check("rst_pc_f", pc_f, 32'd0);
        check("rst_pc_plus4", pc_plus4_f, 32'd0);
        check("rst_imem_addr", {25'd0, imem_addr_o}, 32'd0);
        check("rst_fault", {31'd0, fault_o}, 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) apply_vec(tbl[i]);

        // Asynchronous reset with three entries queued.
        apply_vec(mk(0, 0, 1, 0, 0, 32'h200, 32'h0, 32'h0, 0, 32'h200, 0));
        apply_vec(mk(0, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0, 1, 32'h204, 1));
        apply_vec(mk(0, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0, 1, 32'h208, 1));
        apply_vec(mk(0, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0, 1, 32'h20C, 1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("arst_imem_addr", {25'd0, imem_addr_o}, 32'd0);
        check("arst_pc_f", pc_f, 32'd0);
        check("arst_instr", instr_f, 32'd0);
        sb.delete();
        last = '0; cur_pc = 32'h0; prev_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Misaligned branch target: sticky fault when checked, otherwise word-aligned load.
        exp_fault = MIS;
        apply_vec(mk(0, 0, 0, 1, 0, 32'h0, 32'h42, 32'h0, 0, MIS ? 32'h42 : 32'h40, 0));
        apply_vec(mk(0, 0, 0, 0, 0, 32'h0, 32'h0,  32'h0, !MIS, MIS ? 32'h42 : 32'h44, !MIS));
        apply_vec(mk(0, 0, 0, 0, 0, 32'h0, 32'h0,  32'h0, !MIS, MIS ? 32'h42 : 32'h48, !MIS));
        apply_vec(mk(0, 1, 0, 0, 0, 32'h0, 32'h0,  32'h0, !MIS, MIS ? 32'h42 : 32'h4C, !MIS));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
